uart_rx_datapath: RTL and testbench

Oversampling UART receiver that consumes the serial stream produced by the team's UART transmit stage and returns parallel words to the host. Frame format: idle high, one start bit (0), `word_size` data bits LSB first, one stop bit (1). The block validates the start bit at mid-bit, samples each data bit at mid-bit, and checks the stop bit. It presents the received word through a level ready/acknowledge handshake, with overrun and framing error flags.

---
 rtl/uart_rx_datapath_if.sv | 33 +++
 rtl/uart_rx_datapath.sv | 138 +++++++++++++
 tb/tb_uart_rx_datapath.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_datapath_if.sv
// Host-facing signal bundle of the UART receive datapath: serial line, sample strobe,
// and the received word with its level handshake and error flags.
interface uart_rx_datapath_if #(
  parameter int word_size = 8
);
  logic                 serial_in;
  logic                 sample_en;
  logic                 read_not_ready_in;
  logic [word_size-1:0] rx_datareg;
  logic                 read_not_ready_out;
  logic                 error1;
  logic                 error2;

  modport master (
    output serial_in,
    output sample_en,
    output read_not_ready_in,
    input  rx_datareg,
    input  read_not_ready_out,
    input  error1,
    input  error2
  );

  modport slave (
    input  serial_in,
    input  sample_en,
    input  read_not_ready_in,
    output rx_datareg,
    output read_not_ready_out,
    output error1,
    output error2
  );
endinterface

// File: rtl/uart_rx_datapath.sv
// Oversampling UART receiver: validates the start bit at mid-bit, shifts data LSB first,
// checks the stop bit and hands the word to the host with overrun/framing flags.
module uart_rx_datapath #(
  parameter int word_size       = 8,
  parameter int size_bit_count  = 3,
  parameter int oversample      = 8,
  parameter int oversample_bits = 3
) (
  input logic               clk,
  input logic               rst_b,
  uart_rx_datapath_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, RECV} state_t;

  localparam logic [oversample_bits-1:0] HalfLast   = oversample_bits'(oversample / 2 - 1);
  localparam logic [oversample_bits-1:0] SampleLast = oversample_bits'(oversample - 1);
  localparam logic [size_bit_count:0]    BitLast    = (size_bit_count + 1)'(word_size);

  logic [1:0]                 sync_q;
  logic                       rx_s;
  state_t                     state_q, state_d;
  logic [oversample_bits-1:0] sample_cnt_q, sample_cnt_d;
  logic [size_bit_count:0]    bit_cnt_q, bit_cnt_d;
  logic [word_size-1:0]       rx_shiftreg_q, rx_shiftreg_d;
  logic [word_size-1:0]       rx_datareg_q, rx_datareg_d;
  logic                       rnr_q, rnr_d;
  logic                       error1_q, error1_d;
  logic                       error2_q, error2_d;
  logic                       pending;

  // Two-flop synchronizer; reset to the idle-high line level so no false start is seen.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.serial_in};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      rx_shiftreg_q <= '0;
      rx_datareg_q  <= '0;
      rnr_q         <= 1'b0;
      error1_q      <= 1'b0;
      error2_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shiftreg_q <= rx_shiftreg_d;
      rx_datareg_q  <= rx_datareg_d;
      rnr_q         <= rnr_d;
      error1_q      <= error1_d;
      error2_q      <= error2_d;
    end
  end

  // The acknowledge is applied first so a frame completing on the same edge still loads.
  assign pending = rnr_q & ~bus.read_not_ready_in;

  always_comb begin
    state_d       = state_q;
    sample_cnt_d  = sample_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shiftreg_d = rx_shiftreg_q;
    rx_datareg_d  = rx_datareg_q;
    rnr_d         = rnr_q;
    error1_d      = error1_q;
    error2_d      = error2_q;

    if (bus.read_not_ready_in) begin
      rnr_d    = 1'b0;
      error1_d = 1'b0;
      error2_d = 1'b0;
    end

    if (bus.sample_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d      = START;
            sample_cnt_d = oversample_bits'(1);
          end
        end
        START: begin
          if (rx_s) begin
            state_d      = IDLE;
            sample_cnt_d = '0;
          end else if (sample_cnt_q == HalfLast) begin
            state_d      = RECV;
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        RECV: begin
          if (sample_cnt_q != SampleLast) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end else begin
            sample_cnt_d = '0;
            if (bit_cnt_q < BitLast) begin
              rx_shiftreg_d = {rx_s, rx_shiftreg_q[word_size-1:1]};
              bit_cnt_d     = bit_cnt_q + 1'b1;
            end else begin
              // Stop sample: a low stop bit only flags an error, reception carries on.
              state_d   = IDLE;
              bit_cnt_d = '0;
              if (pending) begin
                error1_d = 1'b1;
              end else begin
                rx_datareg_d = rx_shiftreg_q;
                rnr_d        = 1'b1;
                error2_d     = ~rx_s;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.rx_datareg         = rx_datareg_q;
  assign bus.read_not_ready_out = rnr_q;
  assign bus.error1             = error1_q;
  assign bus.error2             = error2_q;

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Directed bench for uart_rx_datapath: frames are driven bit by bit with 8 strobes per bit
// and every flag/word is compared with hand-computed values.
module tb_uart_rx_datapath;

  logic clk;
  logic rst_b;
  int   assertCount;
  int   failCount;

  uart_rx_datapath_if #(.word_size(8)) busIf ();

  uart_rx_datapath #(
    .word_size(8),
    .size_bit_count(3),
    .oversample(8),
    .oversample_bits(3)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .bus(busIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One sample_en strobe every 4 clocks, leaving the synchronizer time to settle.
  task automatic strobe(input logic ackNow);
    repeat (3) @(negedge clk);
    busIf.sample_en         = 1'b1;
    busIf.read_not_ready_in = ackNow;
    @(negedge clk);
    busIf.sample_en         = 1'b0;
    busIf.read_not_ready_in = 1'b0;
  endtask

  task automatic sendBody(input logic [7:0] data, input logic stopVal);
    busIf.serial_in = 1'b0;
    repeat (8) strobe(1'b0);
    for (int b = 0; b < 8; b++) begin
      busIf.serial_in = data[b];
      repeat (8) strobe(1'b0);
    end
    busIf.serial_in = stopVal;
    repeat (3) strobe(1'b0);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stopVal, input int idle);
    sendBody(data, stopVal);
    strobe(1'b0);
    if (idle > 0) begin
      busIf.serial_in = 1'b1;
      repeat (idle) strobe(1'b0);
    end
  endtask

  task automatic ackPulse();
    @(negedge clk);
    busIf.read_not_ready_in = 1'b1;
    @(negedge clk);
    busIf.read_not_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    assertCount++;
    if (busIf.rx_datareg !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_data: got %h expected 00", busIf.rx_datareg);
    end
    assertCount++;
    if (busIf.read_not_ready_out !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_rnr: got %b expected 0", busIf.read_not_ready_out);
    end
    assertCount++;
    if (busIf.error1 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_err1: got %b expected 0", busIf.error1);
    end
    assertCount++;
    if (busIf.error2 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_err2: got %b expected 0", busIf.error2);
    end
    rst_b = 1'b1;
    repeat (4) strobe(1'b0);
  endtask

  task automatic test_nominal();
    sendBody(8'hA5, 1'b1);
    assertCount++;
    if (busIf.read_not_ready_out !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL nominal_rnr_early: got %b expected 0", busIf.read_not_ready_out);
    end
    strobe(1'b0);
    assertCount++;
    if (busIf.read_not_ready_out !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL nominal_rnr_76: got %b expected 1", busIf.read_not_ready_out);
    end
    assertCount++;
    if (busIf.rx_datareg !== 8'hA5) begin
      failCount++;
      $display("[TB] FAIL nominal_data: got %h expected a5", busIf.rx_datareg);
    end
    assertCount++;
    if (busIf.error1 !== 1'b0 || busIf.error2 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL nominal_errs: got %b%b expected 00", busIf.error1, busIf.error2);
    end
    busIf.serial_in = 1'b1;
    repeat (4) strobe(1'b0);
    ackPulse();
    assertCount++;
    if ({busIf.read_not_ready_out, busIf.error1, busIf.error2} !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL nominal_ack: got %b expected 000",
               {busIf.read_not_ready_out, busIf.error1, busIf.error2});
    end
  endtask

  task automatic test_glitch();
    busIf.serial_in = 1'b0;
    repeat (2) strobe(1'b0);
    busIf.serial_in = 1'b1;
    repeat (12) strobe(1'b0);
    assertCount++;
    if (busIf.read_not_ready_out !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL glitch_rnr: got %b expected 0", busIf.read_not_ready_out);
    end
    sendFrame(8'h5A, 1'b1, 4);
    assertCount++;
    if (busIf.rx_datareg !== 8'h5A) begin
      failCount++;
      $display("[TB] FAIL glitch_data: got %h expected 5a", busIf.rx_datareg);
    end
    assertCount++;
    if (busIf.read_not_ready_out !== 1'b1 || busIf.error2 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL glitch_flags: got rnr=%b err2=%b expected rnr=1 err2=0",
               busIf.read_not_ready_out, busIf.error2);
    end
    ackPulse();
  endtask

  task automatic test_framing();
    sendFrame(8'hFF, 1'b0, 4);
    assertCount++;
    if (busIf.rx_datareg !== 8'hFF) begin
      failCount++;
      $display("[TB] FAIL framing_data: got %h expected ff", busIf.rx_datareg);
    end
    assertCount++;
    if (busIf.read_not_ready_out !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL framing_rnr: got %b expected 1", busIf.read_not_ready_out);
    end
    assertCount++;
    if (busIf.error2 !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL framing_err2: got %b expected 1", busIf.error2);
    end
  endtask

  task automatic test_reset_mid_frame();
    busIf.serial_in = 1'b0;
    repeat (8) strobe(1'b0);
    busIf.serial_in = 1'b1;
    repeat (20) strobe(1'b0);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    assertCount++;
    if (busIf.rx_datareg !== 8'h00 || busIf.read_not_ready_out !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_out: got data=%h rnr=%b expected data=00 rnr=0",
               busIf.rx_datareg, busIf.read_not_ready_out);
    end
    assertCount++;
    if (busIf.error1 !== 1'b0 || busIf.error2 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_errs: got %b%b expected 00", busIf.error1, busIf.error2);
    end
    rst_b = 1'b1;
    repeat (4) strobe(1'b0);
    assertCount++;
    if (busIf.read_not_ready_out !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_partial: got rnr=%b expected 0", busIf.read_not_ready_out);
    end
    sendFrame(8'h3C, 1'b1, 4);
    assertCount++;
    if (busIf.rx_datareg !== 8'h3C) begin
      failCount++;
      $display("[TB] FAIL midreset_data: got %h expected 3c", busIf.rx_datareg);
    end
    assertCount++;
    if (busIf.read_not_ready_out !== 1'b1 || busIf.error1 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_flags: got rnr=%b err1=%b expected rnr=1 err1=0",
               busIf.read_not_ready_out, busIf.error1);
    end
    ackPulse();
  endtask

  task automatic test_overrun();
    sendFrame(8'h11, 1'b1, 4);
    sendFrame(8'h22, 1'b1, 4);
    assertCount++;
    if (busIf.error1 !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL overrun_err1: got %b expected 1", busIf.error1);
    end
    assertCount++;
    if (busIf.rx_datareg !== 8'h11) begin
      failCount++;
      $display("[TB] FAIL overrun_data: got %h expected 11", busIf.rx_datareg);
    end
    sendBody(8'h33, 1'b1);
    strobe(1'b1);
    assertCount++;
    if (busIf.rx_datareg !== 8'h33) begin
      failCount++;
      $display("[TB] FAIL simack_data: got %h expected 33", busIf.rx_datareg);
    end
    assertCount++;
    if (busIf.read_not_ready_out !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL simack_rnr: got %b expected 1", busIf.read_not_ready_out);
    end
    assertCount++;
    if (busIf.error1 !== 1'b0 || busIf.error2 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL simack_errs: got %b%b expected 00", busIf.error1, busIf.error2);
    end
    busIf.serial_in = 1'b1;
    repeat (4) strobe(1'b0);
    ackPulse();
  endtask

  task automatic test_back_to_back();
    sendFrame(8'hC3, 1'b1, 0);
    assertCount++;
    if (busIf.rx_datareg !== 8'hC3 || busIf.read_not_ready_out !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL b2b_first: got data=%h rnr=%b expected data=c3 rnr=1",
               busIf.rx_datareg, busIf.read_not_ready_out);
    end
    ackPulse();
    sendFrame(8'h96, 1'b1, 4);
    assertCount++;
    if (busIf.rx_datareg !== 8'h96) begin
      failCount++;
      $display("[TB] FAIL b2b_second: got %h expected 96", busIf.rx_datareg);
    end
    assertCount++;
    if (busIf.read_not_ready_out !== 1'b1 || busIf.error1 !== 1'b0 || busIf.error2 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_flags: got %b%b%b expected 100",
               busIf.read_not_ready_out, busIf.error1, busIf.error2);
    end
    ackPulse();
  endtask

  // Hard stop in case a stimulus loop never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assertCount             = 0;
    failCount               = 0;
    rst_b                   = 1'b0;
    busIf.serial_in         = 1'b1;
    busIf.sample_en         = 1'b0;
    busIf.read_not_ready_in = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_framing();
    test_reset_mid_frame();
    test_overrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
